// File: rtl/bless_age_alloc.sv
// Age-based output allocator and injection controller for a bufferless
// deflection router. Oldest flit picks first, losers are deflected, and the
// local flit only gets a port left over after all network flits are placed.
module bless_age_alloc #(
    parameter int unsigned AGE_W      = 8,
    parameter int unsigned STARVE_MAX = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_valid,
    input  logic [4*AGE_W-1:0]   in_age,
    input  logic [4*5-1:0]       in_pref,
    input  logic                 inj_req,
    input  logic [AGE_W-1:0]     inj_age,
    input  logic [4:0]           inj_pref,
    output logic                 inj_ack,
    output logic [4:0]           out_valid,
    output logic [5*3-1:0]       out_sel,
    output logic [5*AGE_W-1:0]   out_age,
    output logic [4:0]           out_defl,
    output logic                 starve
);

    localparam int unsigned NLANE = 4;
    localparam int unsigned NOUT  = 5;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned PREF_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        STARVED = 2'd2
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          starve_cnt_q;
    logic                      starve_q;

    logic [NOUT-1:0]           out_valid_q, out_valid_d;
    logic [NOUT*SEL_W-1:0]     out_sel_q,   out_sel_d;
    logic [NOUT*AGE_W-1:0]     out_age_q,   out_age_d;
    logic [NOUT-1:0]           out_defl_q,  out_defl_d;

    logic [1:0]                rank_c [NLANE];
    logic [NOUT-1:0]           free_c;
    logic [3:0]                place_c;
    logic                      inj_ack_c;

    // Saturating age increment.
    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + AGE_W'(1);
    endfunction

    // Port choice for one flit: {deflected, output index}.
    function automatic logic [3:0] place_f(input logic [NOUT-1:0]   free,
                                           input logic [PREF_W-1:0] pref,
                                           input logic              allow_ej);
        logic [2:0] o_sel;
        logic       defl;
        logic       hit;
        o_sel = 3'd0;
        defl  = 1'b0;
        hit   = 1'b0;
        if (allow_ej && pref[4] && free[4]) begin
            o_sel = 3'd4;
        end else begin
            // Descending scan so the lowest matching index is kept.
            for (int o = 3; o >= 0; o--) begin
                if (free[o] && pref[o]) begin
                    o_sel = 3'(o);
                    hit   = 1'b1;
                end
            end
            if (!hit) begin
                defl = 1'b1;
                for (int o = 3; o >= 0; o--) begin
                    if (free[o]) begin
                        o_sel = 3'(o);
                    end
                end
            end
        end
        return {defl, o_sel};
    endfunction

    // Priority rank of each lane: number of valid lanes that beat it.
    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            rank_c[i] = 2'd0;
            for (int j = 0; j < NLANE; j++) begin
                if (j != i && in_valid[j]) begin
                    if ((in_age[j*AGE_W +: AGE_W] > in_age[i*AGE_W +: AGE_W]) ||
                        ((in_age[j*AGE_W +: AGE_W] == in_age[i*AGE_W +: AGE_W]) && (j < i))) begin
                        rank_c[i] = rank_c[i] + 2'd1;
                    end
                end
            end
        end
    end

    // Sequential allocation in rank order, then the injection candidate.
    always_comb begin
        free_c      = '1;
        out_valid_d = '0;
        out_sel_d   = '0;
        out_age_d   = '0;
        out_defl_d  = '0;
        place_c     = 4'd0;
        inj_ack_c   = 1'b0;
        for (int r = 0; r < NLANE; r++) begin
            for (int i = 0; i < NLANE; i++) begin
                if (in_valid[i] && (rank_c[i] == 2'(r))) begin
                    place_c = place_f(free_c, in_pref[i*PREF_W +: PREF_W], 1'b1);
                    free_c[place_c[2:0]]                   = 1'b0;
                    out_valid_d[place_c[2:0]]              = 1'b1;
                    out_defl_d[place_c[2:0]]               = place_c[3];
                    out_sel_d[place_c[2:0]*SEL_W +: SEL_W] = SEL_W'(i);
                    out_age_d[place_c[2:0]*AGE_W +: AGE_W] = sat_inc(in_age[i*AGE_W +: AGE_W]);
                end
            end
        end
        if (inj_req && (|free_c[3:0])) begin
            inj_ack_c = 1'b1;
            place_c   = place_f(free_c, inj_pref, 1'b0);
            out_valid_d[place_c[2:0]]              = 1'b1;
            out_defl_d[place_c[2:0]]               = place_c[3];
            out_sel_d[place_c[2:0]*SEL_W +: SEL_W] = SEL_W'(4);
            out_age_d[place_c[2:0]*AGE_W +: AGE_W] = sat_inc(inj_age);
        end
    end

    assign inj_ack = inj_ack_c & ~rst;

    // Grant registers, aligned with the flit data pipeline stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_sel_q   <= '0;
            out_age_q   <= '0;
            out_defl_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_age_q   <= out_age_d;
            out_defl_q  <= out_defl_d;
        end
    end

    // Injection starvation monitor; any ack or request drop returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inj_req && !inj_ack_c) begin
                        starve_cnt_q <= CNT_W'(1);
                        if (STARVE_MAX <= 1) begin
                            state_q  <= STARVED;
                            starve_q <= 1'b1;
                        end else begin
                            state_q  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (inj_ack_c || !inj_req) begin
                        state_q      <= IDLE;
                        starve_cnt_q <= '0;
                    end else if (starve_cnt_q >= CNT_W'(STARVE_MAX - 1)) begin
                        state_q      <= STARVED;
                        starve_cnt_q <= CNT_W'(STARVE_MAX);
                        starve_q     <= 1'b1;
                    end else begin
                        starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                    end
                end
                STARVED: begin
                    if (inj_ack_c || !inj_req) begin
                        state_q      <= IDLE;
                        starve_cnt_q <= '0;
                        starve_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    starve_cnt_q <= '0;
                    starve_q     <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign out_age   = out_age_q;
    assign out_defl  = out_defl_q;
    assign starve    = starve_q;

endmodule

// File: tb/tb_bless_age_alloc.sv
// Self-checking bench for bless_age_alloc: directed scenarios followed by
// random traffic, all compared against a sort-then-assign reference model.
module tb_bless_age_alloc;

    localparam int unsigned AGE_W      = 8;
    localparam int unsigned STARVE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [31:0]  in_age;
    logic [19:0]  in_pref;
    logic         inj_req;
    logic [7:0]   inj_age;
    logic [4:0]   inj_pref;
    logic         inj_ack;
    logic [4:0]   out_valid;
    logic [14:0]  out_sel;
    logic [39:0]  out_age;
    logic [4:0]   out_defl;
    logic         starve;

    bless_age_alloc #(
        .AGE_W(AGE_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_age(in_age), .in_pref(in_pref),
        .inj_req(inj_req), .inj_age(inj_age), .inj_pref(inj_pref),
        .inj_ack(inj_ack),
        .out_valid(out_valid), .out_sel(out_sel), .out_age(out_age),
        .out_defl(out_defl), .starve(starve)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int streak   = 0;

    logic [4:0]  e_valid, e_defl;
    logic [14:0] e_sel;
    logic [39:0] e_age;
    logic        e_ack, e_starve;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sort lanes oldest-first, then hand out ports in that order.
    task automatic model();
        int order[$];
        bit used[4];
        bit taken[5];
        int best, port, a, lane;
        bit dfl;
        logic [4:0] p;
        e_valid = '0; e_sel = '0; e_age = '0; e_defl = '0; e_ack = 1'b0;
        for (int i = 0; i < 4; i++) used[i] = 1'b0;
        for (int i = 0; i < 5; i++) taken[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            best = -1;
            for (int i = 0; i < 4; i++)
                if (in_valid[i] && !used[i])
                    if (best < 0 || in_age[i*8 +: 8] > in_age[best*8 +: 8]) best = i;
            if (best >= 0) begin
                used[best] = 1'b1;
                order.push_back(best);
            end
        end
        for (int k = 0; k <= order.size(); k++) begin
            if (k < order.size()) begin
                lane = order[k];
                p    = in_pref[lane*5 +: 5];
                a    = int'(in_age[lane*8 +: 8]);
            end else begin
                if (!inj_req || (taken[0] && taken[1] && taken[2] && taken[3])) break;
                e_ack = 1'b1;
                lane  = 4;
                p     = {1'b0, inj_pref[3:0]};
                a     = int'(inj_age);
            end
            port = -1; dfl = 1'b0;
            if (p[4] && !taken[4]) port = 4;
            else begin
                for (int o = 0; o < 4; o++)
                    if (port < 0 && !taken[o] && p[o]) port = o;
                if (port < 0) begin
                    dfl = 1'b1;
                    for (int o = 0; o < 4; o++)
                        if (port < 0 && !taken[o]) port = o;
                end
            end
            taken[port]          = 1'b1;
            e_valid[port]        = 1'b1;
            e_defl[port]         = dfl;
            e_sel[port*3 +: 3]   = 3'(lane);
            e_age[port*8 +: 8]   = 8'((a == 255) ? 255 : a + 1);
        end
    endtask

    // One clock of traffic: drive, check ack, advance, check registered outputs.
    task automatic step(input logic [3:0] v, input logic [31:0] ages, input logic [19:0] prefs,
                        input logic req, input logic [7:0] iage, input logic [4:0] ipref);
        @(negedge clk);
        in_valid = v; in_age = ages; in_pref = prefs;
        inj_req = req; inj_age = iage; inj_pref = ipref;
        #1;
        model();
        check("inj_ack", 64'(inj_ack), 64'(e_ack));
        if (req && !e_ack) streak = (streak < int'(STARVE_MAX)) ? streak + 1 : streak;
        else streak = 0;
        e_starve = (streak >= int'(STARVE_MAX));
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(e_valid));
        check("out_sel",   64'(out_sel),   64'(e_sel));
        check("out_age",   64'(out_age),   64'(e_age));
        check("out_defl",  64'(out_defl),  64'(e_defl));
        check("starve",    64'(starve),    64'(e_starve));
    endtask

    initial begin
        logic [31:0] ages;
        logic [19:0] prefs;
        logic [3:0]  v;
        rst = 1'b1;
        in_valid = 4'hF; in_age = 32'h01020304; in_pref = 20'hFFFFF;
        inj_req = 1'b1; inj_age = 8'd1; inj_pref = 5'b00001;
        repeat (2) @(posedge clk);
        #1;
        check("rst_inj_ack",   64'(inj_ack),   64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sel",   64'(out_sel),   64'd0);
        check("rst_out_age",   64'(out_age),   64'd0);
        check("rst_out_defl",  64'(out_defl),  64'd0);
        check("rst_starve",    64'(starve),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        streak = 0;

        // Ages 9/3/7/5, everyone wants N.
        step(4'hF, {8'd5, 8'd7, 8'd3, 8'd9}, {5'd1, 5'd1, 5'd1, 5'd1}, 1'b0, 8'd0, 5'd0);
        check("tp1_sel",  64'(out_sel[11:0]), 64'({3'd1, 3'd3, 3'd2, 3'd0}));
        check("tp1_defl", 64'(out_defl),      64'(5'b01110));
        check("tp1_age",  64'(out_age[31:0]), 64'({8'd4, 8'd6, 8'd8, 8'd10}));

        // Two eject requests; the older one wins eject.
        step(4'b0101, {8'd0, 8'd6, 8'd0, 8'd4}, {5'd0, 5'b10001, 5'd0, 5'b10001}, 1'b0, 8'd0, 5'd0);
        check("tp2_ej_sel", 64'(out_sel[14:12]), 64'd2);
        check("tp2_n_sel",  64'(out_sel[2:0]),   64'd0);
        check("tp2_defl",   64'(out_defl),       64'd0);

        // Equal ages: lower lane index wins.
        step(4'b1010, {8'd5, 8'd0, 8'd5, 8'd0}, {5'b00010, 5'd0, 5'b00010, 5'd0}, 1'b0, 8'd0, 5'd0);
        check("tp3_e_sel", 64'(out_sel[5:3]), 64'd1);
        check("tp3_n_sel", 64'(out_sel[2:0]), 64'd3);
        check("tp3_defl",  64'(out_defl),     64'(5'b00001));

        // Injection refused for STARVE_MAX cycles, then a port frees up.
        for (int c = 0; c < int'(STARVE_MAX); c++)
            step(4'hF, 32'($urandom), {5'd1, 5'd2, 5'd4, 5'd8}, 1'b1, 8'd3, 5'd1);
        check("tp4_starve_set", 64'(starve), 64'd1);
        step(4'b0111, 32'($urandom), {5'd1, 5'd2, 5'd4, 5'd8}, 1'b1, 8'd3, 5'd1);
        check("tp4_starve_clr", 64'(starve), 64'd0);

        // Saturating age and eject-only local preference.
        step(4'b0001, {24'd0, 8'd255}, {15'd0, 5'b00001}, 1'b1, 8'd3, 5'b10000);
        check("tp5_age_sat",  64'(out_age[7:0]), 64'd255);
        check("tp5_inj_port", 64'(out_sel[5:3]), 64'd4);
        check("tp5_valid",    64'(out_valid),    64'(5'b00011));
        check("tp5_defl",     64'(out_defl),     64'(5'b00010));

        // Reset in the middle of a refused-injection run.
        step(4'hF, 32'h11223344, 20'hFFFFF, 1'b1, 8'd0, 5'd1);
        step(4'hF, 32'h11223344, 20'hFFFFF, 1'b1, 8'd0, 5'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sel",   64'(out_sel),   64'd0);
        check("mid_rst_age",   64'(out_age),   64'd0);
        check("mid_rst_ack",   64'(inj_ack),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        streak = 0;
        // Restarted monitor must need a full run before flagging.
        for (int c = 0; c < int'(STARVE_MAX) + 2; c++)
            step(4'hF, 32'($urandom), 20'($urandom), 1'b1, 8'd9, 5'd2);

        // Random traffic with frequent age ties and saturation.
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 2))
                    0:       ages[i*8 +: 8] = 8'($urandom_range(0, 3));
                    1:       ages[i*8 +: 8] = 8'($urandom_range(252, 255));
                    default: ages[i*8 +: 8] = 8'($urandom);
                endcase
            end
            prefs = 20'($urandom);
            step(v, ages, prefs, ($urandom_range(0, 7) != 0), 8'($urandom), 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
